// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, master ids and request bundle for bus_arbiter
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wd;
  } req_t;

endpackage

// File: rtl/rr_lock_arb.sv
// rtl/rr_lock_arb.sv - round-robin winner select with a bounded M1 lock counter
module rr_lock_arb
  import bus_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  input  logic m1_req,
  input  logic m1_lock,
  input  logic arb_en,
  output logic winner
);

  logic       last_grant;
  logic [7:0] lock_cnt;
  logic       lock_ok;

  assign lock_ok = m1_lock && (lock_cnt < 8'(MAX_LOCK));

  // On a conflict M1 keeps the bus only while its lock budget lasts.
  always_comb begin
    winner = M0;
    if (m0_req && m1_req) begin
      if (last_grant == M1) winner = lock_ok ? M1 : M0;
      else                  winner = M1;
    end else if (m1_req) begin
      winner = M1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= M1;
      lock_cnt   <= '0;
    end else if (arb_en) begin
      last_grant <= winner;
      if (winner == M0)
        lock_cnt <= '0;
      else if (lock_ok)
        lock_cnt <= lock_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master arbiter time-sharing the single bridge data port
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd,
  input  logic        m1_lock,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [3:0]  s_byteen,
  output logic [31:0] s_wd,
  input  logic [31:0] s_rd
);

  state_t state, state_nxt;
  req_t   lat, m0_bundle, m1_bundle;
  logic   owner, winner, arb_en;

  assign m0_bundle = '{addr: m0_addr, we: m0_we, byteen: m0_byteen, wd: m0_wd};
  assign m1_bundle = '{addr: m1_addr, we: m1_we, byteen: m1_byteen, wd: m1_wd};
  assign arb_en    = (state == IDLE) && (m0_req || m1_req);

  rr_lock_arb #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .m0_req  (m0_req),
    .m1_req  (m1_req),
    .m1_lock (m1_lock),
    .arb_en  (arb_en),
    .winner  (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_addr    = '0;
    s_we      = 1'b0;
    s_byteen  = '0;
    s_wd      = '0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    case (state)
      IDLE: if (arb_en) state_nxt = ADDR;
      ADDR: begin
        s_addr    = lat.addr;
        s_we      = lat.we;
        s_byteen  = lat.we ? lat.byteen : 4'b0;
        s_wd      = lat.wd;
        m0_gnt    = (owner == M0);
        m1_gnt    = (owner == M1);
        state_nxt = lat.we ? IDLE : DATA;
      end
      DATA: begin
        s_addr    = lat.addr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is taken at the end of DATA and presented with rvalid one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat       <= '0;
      owner     <= M0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rd     <= '0;
      m1_rd     <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (arb_en) begin
        owner <= winner;
        lat   <= (winner == M1) ? m1_bundle : m0_bundle;
      end
      if (state == DATA) begin
        if (owner == M0) begin
          m0_rd     <= s_rd;
          m0_rvalid <= 1'b1;
        end else begin
          m1_rd     <= s_rd;
          m1_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
